// File: rtl/idex_pipe_stage.sv
// ID/EX pipeline register with valid/ready handshake, one-entry skid buffer,
// flush-to-bubble, occupancy and a saturating flush counter.
//
// Handshake: a transfer happens on a rising edge when valid && ready are both
// high (push = validD && readyD, pop = validE && readyE). readyD depends only
// on registered state. A valid entry holds its payload stable until popped.
module idex_pipe_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int PC_WIDTH   = 32,
    parameter int RF_WIDTH   = 5,
    parameter int CTRL_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  validD,
    output logic                  readyD,
    input  logic [CTRL_WIDTH-1:0] ctrlD,
    input  logic [DATA_WIDTH-1:0] dout1D,
    input  logic [DATA_WIDTH-1:0] dout2D,
    input  logic [PC_WIDTH-1:0]   pcD,
    input  logic [RF_WIDTH-1:0]   regAddr3D,
    input  logic [DATA_WIDTH-1:0] immExtD,
    input  logic                  flushE,
    input  logic                  readyE,
    output logic                  validE,
    output logic [CTRL_WIDTH-1:0] ctrlE,
    output logic [DATA_WIDTH-1:0] dout1E,
    output logic [DATA_WIDTH-1:0] dout2E,
    output logic [PC_WIDTH-1:0]   pcE,
    output logic [RF_WIDTH-1:0]   regAddr3E,
    output logic [DATA_WIDTH-1:0] immExtE,
    output logic [1:0]            occupancy,
    output logic [CNT_WIDTH-1:0]  flushCount,
    output logic [1:0]            dbgState
);

    localparam int PW = CTRL_WIDTH + 3 * DATA_WIDTH + PC_WIDTH + RF_WIDTH;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FULL  = 2'd1,
        S_SKID  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [PW-1:0]        r_main;
    logic [PW-1:0]        r_skid;
    logic [PW-1:0]        w_in;
    logic [CNT_WIDTH-1:0] r_flush_cnt;
    logic                 w_main_valid;
    logic                 w_skid_valid;
    logic                 w_push;
    logic                 w_pop;

    assign w_in         = {ctrlD, dout1D, dout2D, pcD, regAddr3D, immExtD};
    assign w_main_valid = (r_state != S_EMPTY);
    assign w_skid_valid = (r_state == S_SKID);
    assign w_push       = validD && !w_skid_valid;
    assign w_pop        = w_main_valid && readyE;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (flushE) begin
            w_next_state = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: if (w_push) w_next_state = S_FULL;
                S_FULL: begin
                    if (w_push && !w_pop)      w_next_state = S_SKID;
                    else if (!w_push && w_pop) w_next_state = S_EMPTY;
                end
                S_SKID:  if (w_pop) w_next_state = S_FULL;
                default: w_next_state = S_EMPTY;
            endcase
        end
    end

    always_comb begin
        readyD    = 1'b1;
        validE    = 1'b0;
        occupancy = 2'd0;
        case (r_state)
            S_FULL: begin
                validE    = 1'b1;
                occupancy = 2'd1;
            end
            S_SKID: begin
                readyD    = 1'b0;
                validE    = 1'b1;
                occupancy = 2'd2;
            end
            default: begin
                readyD    = 1'b1;
                validE    = 1'b0;
                occupancy = 2'd0;
            end
        endcase
    end

    // Registers are zeroed whenever they go invalid so a bubble reads as a NOP.
    always_ff @(posedge clk) begin
        if (rst || flushE) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            case (r_state)
                S_EMPTY: if (w_push) r_main <= w_in;
                S_FULL: begin
                    if (w_push && w_pop) r_main <= w_in;
                    else if (w_push)     r_skid <= w_in;
                    else if (w_pop)      r_main <= '0;
                end
                S_SKID: begin
                    if (w_pop) begin
                        r_main <= r_skid;
                        r_skid <= '0;
                    end
                end
                default: begin
                    r_main <= '0;
                    r_skid <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flush_cnt <= '0;
        end else if (flushE && (w_main_valid || w_push) && (r_flush_cnt != '1)) begin
            r_flush_cnt <= r_flush_cnt + CNT_WIDTH'(1);
        end
    end

    assign {ctrlE, dout1E, dout2E, pcE, regAddr3E, immExtE} = r_main;
    assign flushCount = r_flush_cnt;
    assign dbgState   = r_state;

endmodule

// File: doc/idex_pipe_stage.md
Name: idex_pipe_stage

Overview:
- Parametrised ID/EX pipeline stage register carrying the decoded control bundle and operands from Decode into Execute.
- Adds valid/ready handshaking on both sides, with a one-entry skid buffer to absorb Execute back-pressure (multi-cycle M-extension ops).
- Flush turns the stage into a bubble.
- Provides an occupancy indication and a saturating flush counter for performance monitoring.

Parameters:
DATA_WIDTH, 32, width of dout1/dout2/immExt
PC_WIDTH, 32, width of pc
RF_WIDTH, 5, register-file address width
CTRL_WIDTH, 16, width of packed control bundle (regWrite, resultSel, memWrite, pcSel, aluCtrl, aluSel, memCtrl, branch; bit 0 = regWrite)
CNT_WIDTH, 16, width of flush counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
validD  in  1  Decode presents a valid instruction
readyD  out  1  stage can accept this cycle
ctrlD  in  CTRL_WIDTH  control bundle
dout1D  in  DATA_WIDTH  rs1 data
dout2D  in  DATA_WIDTH  rs2 data
pcD  in  PC_WIDTH  instruction PC
regAddr3D  in  RF_WIDTH  rd address
immExtD  in  DATA_WIDTH  extended immediate
flushE  in  1  discard all held and incoming entries
readyE  in  1  Execute accepts the output entry this cycle
validE  out  1  output entry valid
ctrlE  out  CTRL_WIDTH  registered control
dout1E  out  DATA_WIDTH  registered rs1 data
dout2E  out  DATA_WIDTH  registered rs2 data
pcE  out  PC_WIDTH  registered PC
regAddr3E  out  RF_WIDTH  registered rd
immExtE  out  DATA_WIDTH  registered immediate
occupancy  out  2  entries held (0, 1 or 2)
flushCount  out  CNT_WIDTH  saturating count of flushes that discarded ≥1 valid entry

Behaviour:
- Single clock clk. Reset rst is synchronous and active-high.
- Storage: main register (drives the *E outputs) and skid register. Each has a valid bit.
- State machine:
  - EMPTY: main invalid
  - FULL: main valid, skid invalid
  - SKID: both valid
- readyD = !skidValid. This is a registered-state decode with no combinational path from readyE. Therefore readyD=1 in EMPTY and FULL, and 0 in SKID.
- Handshake definitions:
  - push = validD && readyD
  - pop = validE && readyE
- Transitions (no flush):
  - EMPTY: push → FULL (main←input).
  - FULL:
    - push&pop → FULL (main←input).
    - push&!pop → SKID (skid←input).
    - !push&pop → EMPTY.
    - Otherwise hold.
  - SKID:
    - pop → FULL (main←skid, skid cleared).
    - Otherwise hold. No push is possible.
- Latency: one cycle from push to validE when the stage is empty. Throughput is one instruction per cycle while readyE=1.
- Payload when main is invalid: all *E outputs read 0. ctrlE=0 gives regWrite=0 and memWrite=0, so a bubble is a NOP for consumers that ignore validE. Popping without refill zeroes the main register.
- Held entries are stable while !readyE. Outputs change only on pop, push-into-empty, flush or reset.
- flushE, next edge:
  - Both registers are invalidated and zeroed, giving state EMPTY.
  - An input pushed in the same cycle is discarded.
  - A pop in the same cycle is still a valid transfer to Execute. Flush does not retract the current output.
- flushCount increments by 1 on a flush edge if mainValid or skidValid was set, or if push occurred. It saturates at all-ones with no wrap.
- rst: priority over flushE and all handshakes. Next edge gives EMPTY, all outputs 0, occupancy=0, flushCount=0. Reset mid-SKID loses both entries and does not count as a flush.
- occupancy = mainValid + skidValid, registered-state derived.

Test Plan:
- Streaming: readyE=1, push pc=0x100,0x104,0x108 on consecutive cycles → validE one cycle later each, pcE follows in order, occupancy stays 1, readyD stays 1.
- Back-pressure: FULL with pc=0x200, readyE=0, push pc=0x204 → SKID, readyD=0, pcE holds 0x200. Raise readyE → pcE=0x204 next cycle, then EMPTY with all outputs 0.
- Flush in SKID: entries 0x300/0x304 held, flushE=1 with validD=1 pc=0x308 → next cycle validE=0, ctrlE=0, occupancy=0, flushCount=1. 0x308 is never seen.
- Flush on empty: flushE=1 with validD=0 in EMPTY → flushCount unchanged.
- Counter saturation: CNT_WIDTH=2, four flushes each discarding an entry → flushCount=3 and remains 3.
- Reset mid-operation: SKID state with flushCount=5, rst=1 for one edge (flushE also 1) → all outputs 0, occupancy=0, flushCount=0, readyD=1.
